uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin scheduler sharing the single `&&data&&` UART string framer among NUM_REQ independent requesters. Each requester posts a string/length with a valid/ready handshake. The block latches and serialises the requests, launches the framer one frame at a time, and returns a per-requester completion or error pulse. It sits between application logic (measurement reporters, command echo) and the string framer's tx_string/tx_length/tx_req/tx_busy/tx_done port.

## Interface
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BYTES, 32, maximum content bytes per frame; STR_W = 8*MAX_BYTES.
- TIMEOUT_CYCLES, 2_000_000, cycles allowed between launch and framer completion.

Ports:
- sys_clk  in  1  clock
- sys_rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester request strobe
- req_ready  out  NUM_REQ  requester slot free (= !pending[i])
- req_string  in  NUM_REQ*STR_W  requester i's string at bits [i*STR_W +: STR_W]; byte k at [8k+7:8k]
- req_length  in  NUM_REQ*8  requester i's length at [i*8 +: 8]
- req_done  out  NUM_REQ  one-cycle pulse: frame sent
- req_err  out  NUM_REQ  one-cycle pulse: request rejected or timed out
- fr_string  out  STR_W  to framer tx_string (holding register)
- fr_length  out  8  to framer tx_length
- fr_req  out  1  one-cycle launch pulse to framer
- fr_busy  in  1  framer busy
- fr_done  in  1  framer one-cycle completion pulse
- busy  out  1  state != IDLE
- grant_id  out  3  index of requester currently served

## Operation
- Capture: on req_valid[i] && req_ready[i], latch request i's string and length into slot i and set pending[i]. While pending[i] is set, req_valid[i] is ignored.
- States: IDLE, ARB, LAUNCH, WAIT_DONE, RELEASE.
- IDLE: go to ARB when (|pending) && !fr_busy; otherwise stay.
- ARB: search pending from ptr upward, mod NUM_REQ; first hit is g. Load fr_string/fr_length from slot g and set grant_id = g.
  - If slot length > MAX_BYTES: go to RELEASE with err, no launch.
  - Otherwise go to LAUNCH.
- LAUNCH: fr_req = 1 for exactly this cycle; clear timeout counter; go to WAIT_DONE.
- WAIT_DONE: increment counter each cycle.
  - fr_done: go to RELEASE with ok.
  - Counter reaches TIMEOUT_CYCLES-1 without fr_done: go to RELEASE with err.
- RELEASE: pulse req_done[g] (ok) or req_err[g] (err) for one cycle. Clear pending[g]. Set ptr = (g+1) mod NUM_REQ. Go to IDLE.
- Length 0 is legal: it is forwarded and the framer emits an empty frame.
- fr_string/fr_length hold their value from ARB until the next ARB, so they stay stable through the whole framer transaction.
- fr_done received outside WAIT_DONE is ignored.

## Timing
- Reset values:
  - state IDLE; ptr 0; pending 0; req_ready all 1.
  - req_done, req_err, fr_req, busy: 0.
  - grant_id 0; fr_string 0; fr_length 0; timeout counter 0.
- Launch latency, with the arbiter idle and the framer not busy: req_valid in cycle t gives pending in t+1, ARB in t+2, and fr_req high in t+3.
- req_done/req_err pulse one cycle after fr_done (in the RELEASE cycle).
- req_ready[g] returns to 1 in the cycle after RELEASE. A new request from g is accepted from then on.
- Back-to-back requests: the next ARB is no earlier than 2 cycles after RELEASE (RELEASE → IDLE → ARB), and it also waits for !fr_busy.
- Simultaneous req_valid from several requesters in one cycle: all are captured; service order is round-robin from ptr.
- Fairness: a continuously re-requesting source cannot be served twice while another requester is pending.
- Timeout: req_err fires exactly TIMEOUT_CYCLES+1 cycles after the fr_req cycle.
- Reset mid-operation (any state): all pending requests are discarded and no done/err pulse is issued. fr_req deasserts immediately (asynchronously).

## Test plan
- Single request: requester 2 sends "AB", length 2. Expect fr_req 3 cycles later with fr_length=2 and fr_string[15:0]=16'h4241. Model fr_done 10 cycles later; expect req_done[2] the next cycle and req_ready[2]=1 after that.
- Simultaneous: all 4 requesters strobe in the same cycle after reset. Expect grants in order 0,1,2,3, each fr_req only after the previous fr_done, and exactly one req_done per requester.
- Fairness: requester 0 re-requests immediately after every done while requester 3 is pending. Expect grant order 0,3,0,3.
- Errors:
  - Length 33 with MAX_BYTES=32: expect req_err pulse, no fr_req.
  - With TIMEOUT_CYCLES=100 and fr_done withheld: expect req_err 101 cycles after fr_req, then the next pending requester served.
- Framer busy: hold fr_busy=1 while requests are pending. Expect no ARB or fr_req until fr_busy falls, then launch 2 cycles later.
- Reset in WAIT_DONE with 2 requests pending: after release, pending=0, req_ready all 1, busy=0, and no req_done/req_err is ever emitted for them.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one string framer among NUM_REQ requesters; launch 3 cycles after an idle request.
// Requesters are held off per slot (req_ready low) until their frame completes or is rejected.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int MAX_BYTES      = 32,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*8*MAX_BYTES-1:0]  req_string,
    input  logic [NUM_REQ*8-1:0]            req_length,
    output logic [NUM_REQ-1:0]              req_done,
    output logic [NUM_REQ-1:0]              req_err,
    output logic [8*MAX_BYTES-1:0]          fr_string,
    output logic [7:0]                      fr_length,
    output logic                            fr_req,
    input  logic                            fr_busy,
    input  logic                            fr_done,
    output logic                            busy,
    output logic [2:0]                      grant_id
);

    localparam int STR_W = 8 * MAX_BYTES;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W:0]   NREQ_W   = (IDX_W + 1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [7:0]       LEN_MAX  = 8'(MAX_BYTES);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_LAUNCH,
        S_WAIT_DONE,
        S_RELEASE
    } state_t;

    state_t             state;
    logic [NUM_REQ-1:0] pending;
    logic [STR_W-1:0]   slot_str [NUM_REQ];
    logic [7:0]         slot_len [NUM_REQ];
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   gnt;
    logic [CNT_W-1:0]   tmo_cnt;

    logic [IDX_W-1:0]   arb_idx;
    logic               arb_hit;
    logic [IDX_W:0]     arb_sum;

    assign req_ready = ~pending;
    assign busy      = (state != S_IDLE);
    assign grant_id  = 3'(gnt);

    // First pending slot at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        arb_idx = ptr;
        arb_hit = 1'b0;
        arb_sum = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            arb_sum = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (arb_sum >= NREQ_W) begin
                arb_sum = arb_sum - NREQ_W;
            end
            if (!arb_hit && pending[arb_sum[IDX_W-1:0]]) begin
                arb_hit = 1'b1;
                arb_idx = arb_sum[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= S_IDLE;
            pending   <= '0;
            ptr       <= '0;
            gnt       <= '0;
            tmo_cnt   <= '0;
            req_done  <= '0;
            req_err   <= '0;
            fr_req    <= 1'b0;
            fr_string <= '0;
            fr_length <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_str[i] <= '0;
                slot_len[i] <= '0;
            end
        end else begin
            req_done <= '0;
            req_err  <= '0;
            fr_req   <= 1'b0;

            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && !pending[i]) begin
                    pending[i]  <= 1'b1;
                    slot_str[i] <= req_string[i*STR_W +: STR_W];
                    slot_len[i] <= req_length[i*8 +: 8];
                end
            end

            case (state)
                S_IDLE: begin
                    if ((|pending) && !fr_busy) begin
                        state <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (!arb_hit) begin
                        state <= S_IDLE;
                    end else begin
                        // Framer inputs are held from here until the next ARB.
                        gnt       <= arb_idx;
                        fr_string <= slot_str[arb_idx];
                        fr_length <= slot_len[arb_idx];
                        if (slot_len[arb_idx] > LEN_MAX) begin
                            req_err[arb_idx] <= 1'b1;
                            state            <= S_RELEASE;
                        end else begin
                            fr_req <= 1'b1;
                            state  <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    tmo_cnt <= '0;
                    state   <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    tmo_cnt <= tmo_cnt + CNT_W'(1);
                    if (fr_done) begin
                        req_done[gnt] <= 1'b1;
                        state         <= S_RELEASE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        req_err[gnt] <= 1'b1;
                        state        <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    pending[gnt] <= 1'b0;
                    ptr          <= (gnt == LAST_IDX) ? '0 : gnt + IDX_W'(1);
                    state        <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: latency, round-robin order, fairness, errors, framer busy, reset.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int MB = 32;
    localparam int SW = 8 * MB;
    localparam int TO = 100;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*SW-1:0]  req_string;
    logic [NR*8-1:0]   req_length;
    logic [NR-1:0]     req_done;
    logic [NR-1:0]     req_err;
    logic [SW-1:0]     fr_string;
    logic [7:0]        fr_length;
    logic              fr_req;
    logic              fr_busy;
    logic              fr_done;
    logic              busy;
    logic [2:0]        grant_id;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt [NR] = '{default: 0};
    int err_cnt  [NR] = '{default: 0};
    int launch_cnt = 0;
    int base_done [NR];
    int base_err  [NR];
    int base_launch;

    uart_tx_arbiter #(
        .NUM_REQ        (NR),
        .MAX_BYTES      (MB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_string (req_string),
        .req_length (req_length),
        .req_done   (req_done),
        .req_err    (req_err),
        .fr_string  (fr_string),
        .fr_length  (fr_length),
        .fr_req     (fr_req),
        .fr_busy    (fr_busy),
        .fr_done    (fr_done),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    always #5 sys_clk = ~sys_clk;

    // Pulse counters sample pre-edge values, so each one-cycle pulse counts once.
    always @(posedge sys_clk) begin
        for (int i = 0; i < NR; i++) begin
            if (req_done[i]) done_cnt[i] <= done_cnt[i] + 1;
            if (req_err[i])  err_cnt[i]  <= err_cnt[i] + 1;
        end
        if (fr_req) launch_cnt <= launch_cnt + 1;
    end

    task automatic cyc();
        @(negedge sys_clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait for a launch, check grant and length, then complete it gap cycles later.
    task automatic serve(input int g, input int len, input int gap);
        int n = 0;
        while (fr_req !== 1'b1 && n < 40) begin
            cyc();
            n++;
        end
        chk("serve_launch", 32'(fr_req), 1);
        chk("serve_grant", 32'(grant_id), g);
        chk("serve_len", 32'(fr_length), len);
        cyc();
        chk("serve_pulse1", 32'(fr_req), 0);
        repeat (gap - 1) cyc();
        fr_done = 1'b1;
        cyc();
        fr_done = 1'b0;
        chk("serve_done", 32'(req_done), 1 << g);
    endtask

    initial begin
        req_valid  = '0;
        req_string = '0;
        req_length = '0;
        fr_busy    = 1'b0;
        fr_done    = 1'b0;
        repeat (2) cyc();

        // Reset values
        chk("rst_ready", 32'(req_ready), 32'hF);
        chk("rst_done", 32'(req_done), 0);
        chk("rst_err", 32'(req_err), 0);
        chk("rst_fr_req", 32'(fr_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_len", 32'(fr_length), 0);
        chk("rst_str", fr_string[31:0], 0);
        sys_rst_n = 1'b1;
        cyc();

        // Single request from requester 2: "AB", length 2
        req_string[2*SW +: 16] = 16'h4241;
        req_length[2*8 +: 8]   = 8'd2;
        req_valid = 4'b0100;
        cyc();
        req_valid = '0;
        chk("t1_pending", 32'(req_ready), 32'hB);
        chk("t1_idle", 32'(busy), 0);
        cyc();
        chk("t1_arb_busy", 32'(busy), 1);
        chk("t1_no_launch", 32'(fr_req), 0);
        cyc();
        chk("t1_fr_req", 32'(fr_req), 1);
        chk("t1_len", 32'(fr_length), 2);
        chk("t1_str", 32'(fr_string[15:0]), 32'h4241);
        chk("t1_grant", 32'(grant_id), 2);
        repeat (10) cyc();
        fr_done = 1'b1;
        cyc();
        fr_done = 1'b0;
        chk("t1_done", 32'(req_done), 32'h4);
        chk("t1_ready_rel", 32'(req_ready), 32'hB);
        cyc();
        chk("t1_done_off", 32'(req_done), 0);
        chk("t1_ready_back", 32'(req_ready), 32'hF);
        chk("t1_len_held", 32'(fr_length), 2);
        chk("t1_idle_end", 32'(busy), 0);

        // Simultaneous requests after reset: order 0,1,2,3
        sys_rst_n = 1'b0;
        cyc();
        sys_rst_n = 1'b1;
        cyc();
        base_done   = done_cnt;
        base_launch = launch_cnt;
        req_length = {8'd8, 8'd7, 8'd6, 8'd5};
        req_valid  = 4'hF;
        cyc();
        req_valid = '0;
        chk("t2_all_pending", 32'(req_ready), 0);
        serve(0, 5, 3);
        serve(1, 6, 3);
        serve(2, 7, 3);
        serve(3, 8, 3);
        cyc();
        for (int i = 0; i < NR; i++) chk("t2_one_done", done_cnt[i] - base_done[i], 1);
        chk("t2_launches", launch_cnt - base_launch, 4);

        // Fairness: requester 0 keeps requesting while 3 is pending
        req_valid = 4'b1001;
        serve(0, 5, 2);
        serve(3, 8, 2);
        serve(0, 5, 2);
        serve(3, 8, 2);
        req_valid = '0;
        serve(0, 5, 2);
        cyc();
        chk("t3_drained", 32'(req_ready), 32'hF);

        // Oversized length from requester 1: error, no launch
        base_launch = launch_cnt;
        req_length[1*8 +: 8] = 8'd33;
        req_valid = 4'b0010;
        cyc();
        req_valid = '0;
        cyc();
        cyc();
        chk("t4_err", 32'(req_err), 32'h2);
        chk("t4_no_done", 32'(req_done), 0);
        chk("t4_no_req", 32'(fr_req), 0);
        chk("t4_len", 32'(fr_length), 33);
        chk("t4_grant", 32'(grant_id), 1);
        cyc();
        chk("t4_err_off", 32'(req_err), 0);
        chk("t4_ready", 32'(req_ready), 32'hF);
        chk("t4_launches", launch_cnt - base_launch, 0);

        // Timeout on requester 2, then requester 3 served
        req_valid = 4'b1100;
        cyc();
        req_valid = '0;
        cyc();
        cyc();
        chk("t5_launch", 32'(fr_req), 1);
        chk("t5_grant", 32'(grant_id), 2);
        repeat (TO) cyc();
        chk("t5_not_yet", 32'(req_err), 0);
        chk("t5_waiting", 32'(busy), 1);
        cyc();
        chk("t5_err", 32'(req_err), 32'h4);
        chk("t5_no_done", 32'(req_done), 0);
        serve(3, 8, 2);

        // Framer busy holds off arbitration
        req_length[1*8 +: 8] = 8'd6;
        fr_busy   = 1'b1;
        req_valid = 4'b0010;
        cyc();
        req_valid = '0;
        repeat (4) begin
            cyc();
            chk("t6_held_busy", 32'(busy), 0);
            chk("t6_held_req", 32'(fr_req), 0);
        end
        fr_busy = 1'b0;
        cyc();
        chk("t6_arb", 32'(busy), 1);
        chk("t6_arb_noreq", 32'(fr_req), 0);
        cyc();
        chk("t6_launch", 32'(fr_req), 1);
        chk("t6_grant", 32'(grant_id), 1);
        cyc();
        fr_done = 1'b1;
        cyc();
        fr_done = 1'b0;
        chk("t6_done", 32'(req_done), 32'h2);

        // Reset in WAIT_DONE with requesters 0 and 2 pending
        cyc();
        req_valid = 4'b0101;
        cyc();
        req_valid = '0;
        cyc();
        cyc();
        chk("t7_launch", 32'(fr_req), 1);
        chk("t7_grant", 32'(grant_id), 2);
        cyc();
        cyc();
        base_done   = done_cnt;
        base_err    = err_cnt;
        base_launch = launch_cnt;
        sys_rst_n = 1'b0;
        #1;
        chk("t7_async_busy", 32'(busy), 0);
        chk("t7_async_ready", 32'(req_ready), 32'hF);
        chk("t7_async_grant", 32'(grant_id), 0);
        cyc();
        sys_rst_n = 1'b1;
        repeat (2) cyc();
        fr_done = 1'b1;
        cyc();
        fr_done = 1'b0;
        repeat (10) cyc();
        chk("t7_ready", 32'(req_ready), 32'hF);
        chk("t7_busy", 32'(busy), 0);
        chk("t7_launches", launch_cnt - base_launch, 0);
        for (int i = 0; i < NR; i++) begin
            chk("t7_no_done", done_cnt[i] - base_done[i], 0);
            chk("t7_no_err", err_cnt[i] - base_err[i], 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
